rv_lsu: RTL and testbench



---
 rtl/rv_lsu_if.sv | 49 ++++
 rtl/rv_lsu.sv | 169 ++++++++++++++++
 tb/tb_rv_lsu.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_lsu_if.sv
`default_nettype none
// ============================================================================
// rv_lsu_if : core-side and memory-side handshake bundles for rv_lsu
// Rev 1.0
// ============================================================================
interface rv_lsu_core_if #(parameter int XLEN = 32);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [4:0]      req_rd;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic [4:0]      rsp_rd;
    logic [1:0]      rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_fault
    );
endinterface

interface rv_lsu_mem_if #(parameter int XLEN = 32);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrobe;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe,
        input  mem_gnt, mem_rvalid, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrobe,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// ============================================================================
// rv_lsu : registered single-outstanding load/store unit (lanes, extension,
//          alignment check, bus timeout). Optional: RV_LSU_MISALIGNED_SPLIT_EN
// Rev 1.0
// ============================================================================
module rv_lsu #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic    clk,
    input  wire logic    nreset,
    rv_lsu_core_if.slave core_if,
    rv_lsu_mem_if.master mem_if
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [TW-1:0] c_TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

`ifdef RV_LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {S_IDLE = 3'd0, S_REQ = 3'd1, S_WAIT = 3'd2, S_RESP = 3'd3,
                              S_REQ2 = 3'd4, S_WAIT2 = 3'd5} state_t;
    localparam logic c_SPLIT = 1'b1;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;
    localparam logic c_SPLIT = 1'b0;
`endif

    state_t            r_state, w_next;
    logic              r_we;
    logic [2:0]        r_f3;
    logic [XLEN-1:0]   r_addr, r_wdata, r_rdata;
    logic [4:0]        r_rd;
    logic [1:0]        r_fault;
    logic [TW-1:0]     r_tmo;
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
    logic [XLEN-1:0]   r_lo;
    logic              w_cross;
`endif

    logic [OW-1:0]     w_off_in, w_amask_in, w_off;
    logic              w_illegal_in, w_misal_in;
    logic [1:0]        w_fault_in;
    logic [NB-1:0]     w_mask;
    logic [2*NB-1:0]   w_strb_wide;
    logic [2*XLEN-1:0] w_wdat_wide, w_rd_wide;
    logic [XLEN-1:0]   w_merged, w_load;
    logic              w_hi_beat, w_rdone, w_tmo_hit;

    // Classify the incoming request before it is latched.
    always_comb begin
        w_illegal_in = (core_if.req_funct3 == 3'b111) ||
                       (core_if.req_we && core_if.req_funct3[2]) ||
                       ((XLEN == 32) && ((core_if.req_funct3 == 3'b011) ||
                                         (core_if.req_funct3 == 3'b110)));
        w_amask_in   = OW'((1 << core_if.req_funct3[1:0]) - 1);
        w_off_in     = core_if.req_addr[OW-1:0];
        w_misal_in   = (w_off_in & w_amask_in) != '0;
        w_fault_in   = w_illegal_in ? 2'd2 : ((w_misal_in && !c_SPLIT) ? 2'd1 : 2'd0);
    end

    // Lane positioning works on a double-width window so a split access
    // simply takes its second beat from the upper half.
    always_comb begin
        w_off       = r_addr[OW-1:0];
        w_mask      = NB'((1 << (1 << r_f3[1:0])) - 1);
        w_strb_wide = {{NB{1'b0}}, w_mask} << w_off;
        w_wdat_wide = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
        w_cross     = (int'(w_off) + (1 << r_f3[1:0])) > NB;
        w_hi_beat   = (r_state == S_REQ2) || (r_state == S_WAIT2);
        w_rd_wide   = w_hi_beat ? {mem_if.mem_rdata, r_lo} : {{XLEN{1'b0}}, mem_if.mem_rdata};
        w_rdone     = mem_if.mem_rvalid && ((r_state == S_WAIT) || (r_state == S_WAIT2));
`else
        w_hi_beat   = 1'b0;
        w_rd_wide   = {{XLEN{1'b0}}, mem_if.mem_rdata};
        w_rdone     = mem_if.mem_rvalid && (r_state == S_WAIT);
`endif
        w_merged    = XLEN'(w_rd_wide >> {w_off, 3'b000});
        case (r_f3[1:0])
            2'd0:    w_load = r_f3[2] ? XLEN'(w_merged[7:0])  : XLEN'($signed(w_merged[7:0]));
            2'd1:    w_load = r_f3[2] ? XLEN'(w_merged[15:0]) : XLEN'($signed(w_merged[15:0]));
            2'd2:    w_load = r_f3[2] ? XLEN'(w_merged[31:0]) : XLEN'($signed(w_merged[31:0]));
            default: w_load = w_merged;
        endcase
        w_tmo_hit   = (TIMEOUT_CYCLES != 0) && (r_tmo == c_TMO_LAST);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (core_if.req_valid) w_next = (w_fault_in != 2'd0) ? S_RESP : S_REQ;
            S_REQ:  if (mem_if.mem_gnt) w_next = S_WAIT;
                    else if (w_tmo_hit) w_next = S_RESP;
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
            S_WAIT: if (w_rdone) w_next = w_cross ? S_REQ2 : S_RESP;
                    else if (w_tmo_hit) w_next = S_RESP;
            S_REQ2: if (mem_if.mem_gnt) w_next = S_WAIT2;
                    else if (w_tmo_hit) w_next = S_RESP;
            S_WAIT2: if (w_rdone || w_tmo_hit) w_next = S_RESP;
`else
            S_WAIT: if (w_rdone || w_tmo_hit) w_next = S_RESP;
`endif
            S_RESP: if (core_if.rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state <= S_IDLE;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rd    <= '0;
            r_fault <= '0;
            r_rdata <= '0;
            r_tmo   <= '0;
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
            r_lo    <= '0;
`endif
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && core_if.req_valid) begin
                r_we    <= core_if.req_we;
                r_f3    <= core_if.req_funct3;
                r_addr  <= core_if.req_addr;
                r_wdata <= core_if.req_wdata;
                r_rd    <= core_if.req_rd;
                r_fault <= w_fault_in;
                r_rdata <= '0;
                r_tmo   <= '0;
            end else if ((r_state != S_IDLE) && (r_state != S_RESP)) begin
                r_tmo <= r_tmo + 1'b1;
                // Leaving a bus state for RESP without data can only be a timeout.
                if (w_next == S_RESP) begin
                    r_fault <= w_rdone ? 2'd0 : 2'd3;
                    r_rdata <= (w_rdone && !r_we) ? w_load : '0;
                end
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
                if (w_next == S_REQ2) begin
                    r_tmo <= '0;
                    r_lo  <= mem_if.mem_rdata;
                end
`endif
            end
        end
    end

    assign core_if.req_ready = (r_state == S_IDLE);
    assign core_if.rsp_valid = (r_state == S_RESP);
    assign core_if.rsp_rdata = r_rdata;
    assign core_if.rsp_rd    = r_rd;
    assign core_if.rsp_fault = r_fault;

`ifdef RV_LSU_MISALIGNED_SPLIT_EN
    assign mem_if.mem_req = (r_state == S_REQ) || (r_state == S_REQ2);
`else
    assign mem_if.mem_req = (r_state == S_REQ);
`endif
    assign mem_if.mem_we      = r_we;
    assign mem_if.mem_addr    = {r_addr[XLEN-1:OW], {OW{1'b0}}} + (w_hi_beat ? XLEN'(NB) : '0);
    assign mem_if.mem_wdata   = w_hi_beat ? w_wdat_wide[2*XLEN-1:XLEN] : w_wdat_wide[XLEN-1:0];
    assign mem_if.mem_wstrobe = !r_we ? '0 :
                                (w_hi_beat ? w_strb_wide[2*NB-1:NB] : w_strb_wide[NB-1:0]);
endmodule
`default_nettype wire

// File: tb/tb_rv_lsu.sv
`default_nettype none
// ============================================================================
// tb_rv_lsu : directed self-checking bench for rv_lsu (XLEN=32, timeout 8)
// Rev 1.0
// ============================================================================
module tb_rv_lsu;
    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    rv_lsu_core_if #(.XLEN(32)) cif ();
    rv_lsu_mem_if  #(.XLEN(32)) mif ();

    rv_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .core_if (cif),
        .mem_if  (mif)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus responder configuration (written by the main sequence only).
    int          cfg_gnt_dly = 0;
    int          cfg_rv_dly  = 0;
    logic [31:0] cfg_rd0     = '0;
    logic [31:0] cfg_rd1     = '0;
    int          cfg_epoch   = 0;
    int          late_req    = 0;

    // Responder-owned state and observations.
    int          seen_epoch  = 0;
    int          late_seen   = 0;
    bit          rv_pending  = 0;
    int          rv_wait     = 0;
    int          gnt_wait    = 0;
    int          beat        = 0;
    int          req_cycles  = 0;
    int          n_grants    = 0;
    logic [31:0] rec_addr0 = '0, rec_addr1 = '0, rec_wdata0 = '0;
    logic [3:0]  rec_strb0 = '0;
    logic        rec_we0   = 1'b0;

    always @(posedge clk) begin
        #1;
        if (seen_epoch != cfg_epoch) begin
            seen_epoch = cfg_epoch;
            rv_pending = 0; rv_wait = 0; gnt_wait = 0; beat = 0;
            req_cycles = 0; n_grants = 0;
            rec_addr0 = '0; rec_addr1 = '0; rec_wdata0 = '0; rec_strb0 = '0; rec_we0 = 1'b0;
        end
        mif.mem_gnt    = 1'b0;
        mif.mem_rvalid = 1'b0;
        if (mif.mem_req) req_cycles++;
        if (rv_pending) begin
            if (rv_wait == 0) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = (beat == 0) ? cfg_rd0 : cfg_rd1;
                beat++;
                rv_pending = 0;
            end else begin
                rv_wait--;
            end
        end else if (mif.mem_req) begin
            if (cfg_gnt_dly >= 0 && gnt_wait >= cfg_gnt_dly) begin
                mif.mem_gnt = 1'b1;
                if (n_grants == 0) begin
                    rec_addr0 = mif.mem_addr; rec_wdata0 = mif.mem_wdata;
                    rec_strb0 = mif.mem_wstrobe; rec_we0 = mif.mem_we;
                end else begin
                    rec_addr1 = mif.mem_addr;
                end
                n_grants++;
                gnt_wait   = 0;
                rv_pending = 1;
                rv_wait    = cfg_rv_dly;
            end else begin
                gnt_wait++;
            end
        end else if (late_seen != late_req) begin
            late_seen      = late_req;
            mif.mem_rvalid = 1'b1;
            mif.mem_rdata  = 32'hBAD0BAD0;
        end
    end

    int          got_lat;
    bit          got_valid;
    logic [31:0] got_rdata;
    logic [1:0]  got_fault;
    logic [4:0]  got_rd;

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int gdly, input int rdly, input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        check({tag, "_ready"}, cif.req_ready, 1'b1);
        cfg_gnt_dly = gdly; cfg_rv_dly = rdly; cfg_rd0 = d0; cfg_rd1 = d1;
        cfg_epoch++;
        cif.req_valid = 1'b1; cif.req_we = we; cif.req_funct3 = f3;
        cif.req_addr = addr; cif.req_wdata = wdata; cif.req_rd = rd;
        @(posedge clk);
        got_valid = 0; got_lat = 0; got_rdata = '0; got_fault = '0; got_rd = '0;
        for (int n = 1; n <= 40 && !got_valid; n++) begin
            @(negedge clk);
            cif.req_valid = 1'b0;
            if (cif.rsp_valid) begin
                got_valid = 1; got_lat = n;
                got_rdata = cif.rsp_rdata; got_fault = cif.rsp_fault; got_rd = cif.rsp_rd;
            end else begin
                @(posedge clk);
            end
        end
        check({tag, "_rsp_seen"}, got_valid, 1'b1);
    endtask

    bit stray;

    initial begin
        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_funct3 = '0;
        cif.req_addr = '0; cif.req_wdata = '0; cif.req_rd = '0; cif.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", cif.req_ready, 1'b1);
        check("rst_rsp_valid", cif.rsp_valid, 1'b0);
        check("rst_mem_req", mif.mem_req, 1'b0);
        check("rst_mem_we", mif.mem_we, 1'b0);
        check("rst_strobe", mif.mem_wstrobe, 4'h0);
        check("rst_rdata", cif.rsp_rdata, 32'h0);
        nreset = 1'b1;

        do_req("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 0, 1, 32'h0, 32'h0);
        check("sw_lat", got_lat, 4);
        check("sw_addr", rec_addr0, 32'h100);
        check("sw_strb", rec_strb0, 4'hF);
        check("sw_wdata", rec_wdata0, 32'hDEADBEEF);
        check("sw_we", rec_we0, 1'b1);
        check("sw_fault", got_fault, 2'd0);
        check("sw_rdata", got_rdata, 32'h0);

        do_req("lb", 1'b0, 3'b000, 32'h103, 32'h0, 5'd2, 0, 0, 32'h80FF0000, 32'h0);
        check("lb_rdata", got_rdata, 32'hFFFFFF80);
        check("lb_lat", got_lat, 3);
        check("lb_addr", rec_addr0, 32'h100);
        check("lb_rd", got_rd, 5'd2);

        do_req("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 5'd2, 0, 0, 32'h80FF0000, 32'h0);
        check("lbu_rdata", got_rdata, 32'h00000080);

        do_req("sh", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5'd3, 0, 0, 32'h0, 32'h0);
        check("sh_addr", rec_addr0, 32'h100);
        check("sh_wdata", rec_wdata0, 32'hABCD0000);
        check("sh_strb", rec_strb0, 4'hC);

        do_req("lh", 1'b0, 3'b001, 32'h102, 32'h0, 5'd4, 2, 0, 32'h80010000, 32'h0);
        check("lh_rdata", got_rdata, 32'hFFFF8001);
        check("lh_lat", got_lat, 5);
        check("lh_req_cycles", req_cycles, 3);

        do_req("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 5'd4, 0, 0, 32'h80010000, 32'h0);
        check("lhu_rdata", got_rdata, 32'h00008001);

        do_req("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0, 5'd5, 0, 0, 32'h22110000, 32'h00004433);
        check("lw_mis_rd", got_rd, 5'd5);
`ifdef RV_LSU_MISALIGNED_SPLIT_EN
        check("lw_mis_fault", got_fault, 2'd0);
        check("lw_mis_rdata", got_rdata, 32'h44332211);
        check("lw_mis_grants", n_grants, 2);
        check("lw_mis_addr0", rec_addr0, 32'h100);
        check("lw_mis_addr1", rec_addr1, 32'h104);
`else
        check("lw_mis_fault", got_fault, 2'd1);
        check("lw_mis_lat", got_lat, 1);
        check("lw_mis_req_cycles", req_cycles, 0);
        check("lw_mis_grants", n_grants, 0);
`endif

        do_req("ill_ld", 1'b0, 3'b011, 32'h100, 32'h0, 5'd9, 0, 0, 32'h0, 32'h0);
        check("ill_ld_fault", got_fault, 2'd2);
        check("ill_ld_req_cycles", req_cycles, 0);
        do_req("ill_st", 1'b1, 3'b100, 32'h100, 32'h0, 5'd10, 0, 0, 32'h0, 32'h0);
        check("ill_st_fault", got_fault, 2'd2);

        do_req("tmo", 1'b0, 3'b010, 32'h200, 32'h0, 5'd6, -1, 0, 32'h0, 32'h0);
        check("tmo_fault", got_fault, 2'd3);
        check("tmo_rdata", got_rdata, 32'h0);
        check("tmo_req_cycles", req_cycles, 8);
        check("tmo_lat", got_lat, 9);
        @(negedge clk);
        late_req++;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (cif.rsp_valid || mif.mem_req) stray = 1;
        end
        check("tmo_late_rv_ignored", stray, 1'b0);
        check("tmo_late_ready", cif.req_ready, 1'b1);

        // Reset while the unit waits for read data.
        @(negedge clk);
        cfg_gnt_dly = 0; cfg_rv_dly = 6; cfg_rd0 = 32'hCAFEF00D; cfg_epoch++;
        cif.req_valid = 1'b1; cif.req_we = 1'b0; cif.req_funct3 = 3'b010;
        cif.req_addr = 32'h300; cif.req_rd = 5'd7;
        @(posedge clk);
        @(negedge clk);
        cif.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_wait_grants", n_grants, 1);
        nreset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
        check("midrst_req_ready", cif.req_ready, 1'b1);
        check("midrst_mem_req", mif.mem_req, 1'b0);
        check("midrst_rsp_valid", cif.rsp_valid, 1'b0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (cif.rsp_valid || mif.mem_req) stray = 1;
        end
        check("midrst_late_rv_ignored", stray, 1'b0);

        do_req("lw_after_rst", 1'b0, 3'b010, 32'h300, 32'h0, 5'd8, 0, 0, 32'h12345678, 32'h0);
        check("lw_after_rst_rdata", got_rdata, 32'h12345678);
        check("lw_after_rst_fault", got_fault, 2'd0);
        check("lw_after_rst_rd", got_rd, 5'd8);
        check("lw_after_rst_lat", got_lat, 3);
        check("lw_after_rst_addr", rec_addr0, 32'h300);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
